// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Definitions shared by the LCD message scheduler, its round-robin
//   arbiter and the LCD1604 controller it feeds.
//   Contents:
//     sched_state_t   scheduler FSM states (IDLE, HOLD)
//     LCD_MSG_WIDTH   default width of a message code
//     LCD_IDLE_MSG    default code shown after reset, before any grant
//     MSG_*           named message codes understood by LCD1604_controller
package lcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  localparam int         LCD_MSG_WIDTH = 4;
  localparam logic [3:0] LCD_IDLE_MSG  = 4'b0000;

  // Codes decoded by LCD1604_controller into full screen texts
  localparam logic [3:0] MSG_BLANK      = 4'h0;
  localparam logic [3:0] MSG_WELCOME    = 4'h1;
  localparam logic [3:0] MSG_PLAYING    = 4'h2;
  localparam logic [3:0] MSG_WIN        = 4'h3;
  localparam logic [3:0] MSG_LOSE       = 4'h4;
  localparam logic [3:0] MSG_TEMP_HIGH  = 4'h5;
  localparam logic [3:0] MSG_TEMP_OK    = 4'h6;
  localparam logic [3:0] MSG_SENSOR_ERR = 4'h7;
  localparam logic [3:0] MSG_FAULT      = 4'hF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search for a requester begins
//   at i_ptr and wraps around, so the first set request bit at or after
//   the pointer wins.
//   Ports:
//     i_req     requests, one bit per source
//     i_ptr     index where the search begins
//     o_grant   one-hot grant (all zero when nothing requests)
//     o_idx     encoded index of the granted source
//     o_anyReq  high when at least one request bit is set
module rr_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_anyReq
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Walk the sources starting from the pointer; the first hit wins and
  // later hits are masked off by the found flag so the grant stays one-hot.
  always_comb begin : search
    logic             found;
    logic [IDX_W-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    o_grant  = '0;
    o_idx    = '0;
    o_anyReq = |i_req;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_idx          = cand;
        o_grant[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler
//   Shares one LCD1604 controller between several message sources. One
//   source is granted at a time in round-robin order; its code is latched
//   and held on the display for at least HOLD_CYCLES clocks before the
//   next source may be served. All outputs are registered.
//   Ports:
//     clk          system clock
//     reset        synchronous, active-high
//     req_i        per-source request level
//     msg_i        packed codes, source i at [i*MSG_WIDTH +: MSG_WIDTH]
//     ack_o        one-cycle grant pulse to the winning source
//     mensaje      code driven to the controller
//     ready_o      controller ready_i, high while a message is held
//     busy_o       high while in HOLD
//     active_id_o  index of the source currently displayed
module lcd_msg_scheduler
  import lcd_pkg::*;
#(
  parameter int                   NUM_REQ     = 4,
  parameter int                   MSG_WIDTH   = LCD_MSG_WIDTH,
  parameter int                   HOLD_CYCLES = 50,
  parameter logic [MSG_WIDTH-1:0] IDLE_MSG    = MSG_WIDTH'(LCD_IDLE_MSG)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]   msg_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [MSG_WIDTH-1:0]           mensaje,
  output logic                           ready_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_REQ)-1:0]     active_id_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  sched_state_t         r_state;
  logic [CNT_W-1:0]     r_holdCnt;
  logic [IDX_W-1:0]     r_ptr;
  logic [MSG_WIDTH-1:0] r_msg;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_ready;
  logic                 r_busy;
  logic [IDX_W-1:0]     r_activeId;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_anyReq;
  logic                 w_grantNow;
  logic [IDX_W-1:0]     w_nextPtr;
  logic [MSG_WIDTH-1:0] w_msgSel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_anyReq (w_anyReq)
  );

  // A grant is only allowed from IDLE or once the dwell has fully elapsed;
  // during the rest of HOLD the requests are deliberately ignored.
  assign w_grantNow = w_anyReq && ((r_state == IDLE) || (r_holdCnt == '0));

  // Next search starts just after the winner, wrapping for any NUM_REQ.
  assign w_nextPtr  = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

  assign w_msgSel   = msg_i[int'(w_idx)*MSG_WIDTH +: MSG_WIDTH];

  // Scheduler FSM. The counter is loaded with HOLD_CYCLES-1 at each grant
  // so ready_o covers exactly HOLD_CYCLES cycles; it only counts down, and
  // only a grant reloads it. Leaving HOLD keeps mensaje and active_id_o so
  // the last message stays on screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_holdCnt  <= '0;
      r_ptr      <= '0;
      r_msg      <= IDLE_MSG;
      r_ack      <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_activeId <= '0;
    end else begin
      r_ack <= '0;
      if (w_grantNow) begin
        r_state    <= HOLD;
        r_holdCnt  <= CNT_W'(HOLD_CYCLES - 1);
        r_ptr      <= w_nextPtr;
        r_msg      <= w_msgSel;
        r_ack      <= w_grant;
        r_ready    <= 1'b1;
        r_busy     <= 1'b1;
        r_activeId <= w_idx;
      end else if (r_state == HOLD) begin
        if (r_holdCnt != '0) begin
          r_holdCnt <= r_holdCnt - CNT_W'(1);
        end else begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign ack_o       = r_ack;
  assign mensaje     = r_msg;
  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign active_id_o = r_activeId;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb_lcd_msg_scheduler
//   Self-checking bench for lcd_msg_scheduler with NUM_REQ=4, MSG_WIDTH=4,
//   HOLD_CYCLES=50 and a 20 ns clock. A table of directed vectors, a few
//   hand-written multi-cycle sequences and a randomized phase checked
//   against a behavioural model of the scheduling rules.
module tb_lcd_msg_scheduler;

  localparam int NREQ = 4;
  localparam int MW   = 4;
  localparam int HOLD = 50;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [15:0] msg_i;
  logic [3:0]  ack_o;
  logic [3:0]  mensaje;
  logic        ready_o;
  logic        busy_o;
  logic [1:0]  active_id_o;

  int checks = 0;
  int errors = 0;

  lcd_msg_scheduler #(
    .NUM_REQ     (NREQ),
    .MSG_WIDTH   (MW),
    .HOLD_CYCLES (HOLD),
    .IDLE_MSG    (4'b0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .msg_i       (msg_i),
    .ack_o       (ack_o),
    .mensaje     (mensaje),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .active_id_o (active_id_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Directed vector: inputs held for n cycles, outputs checked after each edge
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] msg;
    int          n;
    logic [3:0]  eAck;
    logic [3:0]  eMsg;
    logic        eRdy;
    logic [1:0]  eId;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic [3:0] req, input logic [15:0] msg,
                        input int n, input logic [3:0] eAck, input logic [3:0] eMsg,
                        input logic eRdy, input logic [1:0] eId);
    vec_t v;
    v.rst = rst; v.req = req; v.msg = msg; v.n = n;
    v.eAck = eAck; v.eMsg = eMsg; v.eRdy = eRdy; v.eId = eId;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then wait past the next rising edge
  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [15:0] msg);
    @(negedge clk);
    reset = rst;
    req_i = req;
    msg_i = msg;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eAck, input logic [3:0] eMsg,
                             input logic eRdy, input logic eBusy, input logic [1:0] eId);
    checks++;
    if (ack_o !== eAck || mensaje !== eMsg || ready_o !== eRdy ||
        busy_o !== eBusy || active_id_o !== eId) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s: got ack=%b msg=%h ready=%b busy=%b id=%0d, expected ack=%b msg=%h ready=%b busy=%b id=%0d",
                 name, ack_o, mensaje, ready_o, busy_o, active_id_o,
                 eAck, eMsg, eRdy, eBusy, eId);
    end
  endtask

  // Behavioural model: tracks how long the current message has been on
  // screen and who was served last; the next winner is the first requester
  // found when counting upward from the last winner.
  logic       mHolding;
  int         mShown;
  int         mLast;
  logic [3:0] mMsg;
  logic [1:0] mId;
  logic [3:0] mAck;

  task automatic modelStep(input logic rst, input logic [3:0] req, input logic [15:0] msg);
    int winner;
    mAck = 4'b0000;
    if (rst) begin
      mHolding = 1'b0; mShown = 0; mLast = -1; mMsg = 4'h0; mId = 2'd0;
    end else if (!mHolding || mShown == HOLD) begin
      winner = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (mLast + k + NREQ) % NREQ;
        if (winner < 0 && req[c]) winner = c;
      end
      if (winner >= 0) begin
        mAck[winner] = 1'b1;
        mMsg         = msg[winner*4 +: 4];
        mId          = 2'(winner);
        mLast        = winner;
        mHolding     = 1'b1;
        mShown       = 1;
      end else begin
        mHolding = 1'b0;
      end
    end else begin
      mShown++;
    end
  endtask

  logic [3:0]  rq;
  logic [15:0] mg;
  logic        rr;

  initial begin
    reset = 1'b1;
    req_i = 4'b0000;
    msg_i = 16'h0000;

    // ---- table-driven directed vectors ----
    // reset, then 100 quiet cycles
    addVec(1, 4'b0000, 16'h0000,   2, 4'b0000, 4'h0, 0, 2'd0);
    addVec(0, 4'b0000, 16'h0000, 100, 4'b0000, 4'h0, 0, 2'd0);
    // single request from src2 with code 9: 50-cycle dwell, then idle
    addVec(0, 4'b0100, 16'h0900,   1, 4'b0100, 4'h9, 1, 2'd2);
    addVec(0, 4'b0000, 16'h0900,  49, 4'b0000, 4'h9, 1, 2'd2);
    addVec(0, 4'b0000, 16'h0900,   5, 4'b0000, 4'h9, 0, 2'd2);
    // all four requesting with codes 1..4: order 0,1,2,3,0 with no gap
    addVec(1, 4'b0000, 16'h4321,   1, 4'b0000, 4'h0, 0, 2'd0);
    addVec(0, 4'b1111, 16'h4321,   1, 4'b0001, 4'h1, 1, 2'd0);
    addVec(0, 4'b1111, 16'h4321,  49, 4'b0000, 4'h1, 1, 2'd0);
    addVec(0, 4'b1111, 16'h4321,   1, 4'b0010, 4'h2, 1, 2'd1);
    addVec(0, 4'b1111, 16'h4321,  49, 4'b0000, 4'h2, 1, 2'd1);
    addVec(0, 4'b1111, 16'h4321,   1, 4'b0100, 4'h3, 1, 2'd2);
    addVec(0, 4'b1111, 16'h4321,  49, 4'b0000, 4'h3, 1, 2'd2);
    addVec(0, 4'b1111, 16'h4321,   1, 4'b1000, 4'h4, 1, 2'd3);
    addVec(0, 4'b1111, 16'h4321,  49, 4'b0000, 4'h4, 1, 2'd3);
    addVec(0, 4'b1111, 16'h4321,   1, 4'b0001, 4'h1, 1, 2'd0);
    addVec(0, 4'b1111, 16'h4321,  49, 4'b0000, 4'h1, 1, 2'd0);
    addVec(0, 4'b0000, 16'h4321,   3, 4'b0000, 4'h1, 0, 2'd0);
    // reset 20 cycles into a hold (with requests present), pointer back at 0
    addVec(0, 4'b0100, 16'h0700,   1, 4'b0100, 4'h7, 1, 2'd2);
    addVec(0, 4'b0000, 16'h0700,  19, 4'b0000, 4'h7, 1, 2'd2);
    addVec(1, 4'b1010, 16'hB0A0,   1, 4'b0000, 4'h0, 0, 2'd0);
    addVec(0, 4'b1010, 16'hB0A0,   1, 4'b0010, 4'hA, 1, 2'd1);
    addVec(0, 4'b0000, 16'hB0A0,  49, 4'b0000, 4'hA, 1, 2'd1);
    addVec(0, 4'b0000, 16'hB0A0,   2, 4'b0000, 4'hA, 0, 2'd1);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].msg);
        checkOutput($sformatf("vec%0d.%0d", i, c), vecs[i].eAck, vecs[i].eMsg,
                    vecs[i].eRdy, vecs[i].eRdy, vecs[i].eId);
      end
    end

    // ---- code change during hold: latched only at grant ----
    applyStimulus(1, 4'b0000, 16'h0000);
    checkOutput("latch_reset", 4'b0000, 4'h0, 0, 0, 2'd0);
    applyStimulus(0, 4'b0001, 16'h000A);
    checkOutput("latch_grant0", 4'b0001, 4'hA, 1, 1, 2'd0);
    repeat (30) applyStimulus(0, 4'b0010, 16'h0050);
    checkOutput("latch_mid", 4'b0000, 4'hA, 1, 1, 2'd0);
    repeat (19) applyStimulus(0, 4'b0010, 16'h0060);
    checkOutput("latch_before_edge", 4'b0000, 4'hA, 1, 1, 2'd0);
    applyStimulus(0, 4'b0010, 16'h0060);
    checkOutput("latch_grant1", 4'b0010, 4'h6, 1, 1, 2'd1);

    // ---- src3 withdraws before its turn; src1 keeps asking ----
    for (int i = 1; i < HOLD; i++) begin
      applyStimulus(0, (i <= 40) ? 4'b1010 : 4'b0010, 16'hC070);
      checkOutput($sformatf("drop_hold%0d", i), 4'b0000, 4'h6, 1, 1, 2'd1);
    end
    applyStimulus(0, 4'b0010, 16'hC070);
    checkOutput("drop_grant1", 4'b0010, 4'h7, 1, 1, 2'd1);
    applyStimulus(0, 4'b0000, 16'hC070);
    checkOutput("drop_after", 4'b0000, 4'h7, 1, 1, 2'd1);

    // ---- randomized sources against the behavioural model ----
    rq = 4'b0000;
    mg = 16'($urandom);
    applyStimulus(1, rq, mg);
    modelStep(1, rq, mg);
    checkOutput("rnd_reset", mAck, mMsg, mHolding, mHolding, mId);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int s = 0; s < NREQ; s++) begin
        if (rq[s]) begin
          if (mAck[s]) begin
            if ($urandom_range(0, 9) < 7) rq[s] = 1'b0;
          end else if ($urandom_range(0, 199) == 0) begin
            rq[s] = 1'b0;
          end
        end else if ($urandom_range(0, 29) == 0) begin
          rq[s] = 1'b1;
          mg[s*4 +: 4] = 4'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) mg[$urandom_range(0, 3)*4 +: 4] = 4'($urandom);
      rr = ($urandom_range(0, 999) == 0);
      applyStimulus(rr, rq, mg);
      modelStep(rr, rq, mg);
      checkOutput($sformatf("rnd%0d", cyc), mAck, mMsg, mHolding, mHolding, mId);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
